fpu_32_arbiter: RTL and testbench

//  Shares one FPU_32 instance between N_REQ requesters. Per-requester valid/ready

---
 rtl/fpu_32_pkg.sv | 26 ++
 rtl/fpu_32_arbiter_rr.sv | 40 ++++
 rtl/fpu_32_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_fpu_32_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_32_pkg.sv
// Shared types and constants for the FPU_32 arbiter: op modes, arbiter FSM states, and the qNaN result.
// The optional FPU_ARB_STATS_EN macro (see fpu_32_arbiter.sv) adds statistics counters.
package fpu_32_pkg;

  typedef enum logic [2:0] {
    MODE_MUL = 3'b000,
    MODE_ADD = 3'b001,
    MODE_SUB = 3'b010,
    MODE_DIV = 3'b011
  } fpu_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // Any mode with the top bit set is not an FPU operation.
  function automatic logic mode_is_illegal(input logic [2:0] mode);
    return mode[2];
  endfunction

endpackage

// File: rtl/fpu_32_arbiter_rr.sv
// Combinational round-robin grant: first requester at or after ptr (wrapping) wins.
// The pointer register lives in the parent.
module fpu_rr_arbiter
  import fpu_32_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant_onehot,
  output logic [ID_W-1:0]  grant_idx,
  output logic             any
);

  logic [ID_W-1:0] scan_idx;

  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= N_REQ) s = s - N_REQ;
    return ID_W'(s);
  endfunction

  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    any          = 1'b0;
    scan_idx     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = wrap_idx(ptr, k);
      if (!any && req[scan_idx]) begin
        any                    = 1'b1;
        grant_idx              = scan_idx;
        grant_onehot[scan_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpu_32_arbiter.sv
// Shares one FPU_32 between N_REQ requesters: round-robin grant, one op in flight, fixed latency.
// Define FPU_ARB_STATS_EN to add the stat_ops / stat_busy counters.
module fpu_32_arbiter
  import fpu_32_pkg::*;
#(
  parameter  int N_REQ     = 4,
  parameter  int LAT_ARITH = 2,
  parameter  int LAT_DIV   = 40,
  localparam int ID_W      = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [3*N_REQ-1:0]    req_mode,
  input  logic [32*N_REQ-1:0]   req_a,
  input  logic [32*N_REQ-1:0]   req_b,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [ID_W-1:0]       resp_id,
  output logic [31:0]           resp_data,
  output logic                  busy,
  output logic [2:0]            fpu_mode,
  output logic [31:0]           fpu_a,
  output logic [31:0]           fpu_b,
  output logic                  fpu_rst_n,
  input  logic [31:0]           fpu_result,
  output arb_state_e            dbg_state
`ifdef FPU_ARB_STATS_EN
  ,
  output logic [31:0]           stat_ops,
  output logic [31:0]           stat_busy
`endif
);

  localparam int LAT_MAX = (LAT_DIV > LAT_ARITH) ? LAT_DIV : LAT_ARITH;
  localparam int CNT_W   = $clog2(LAT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_DIV   = CNT_W'(LAT_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ARITH = CNT_W'(LAT_ARITH - 1);

  arb_state_e       state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             resp_valid_q, resp_valid_d;
  logic [ID_W-1:0]  resp_id_q, resp_id_d;
  logic [31:0]      resp_data_q, resp_data_d;
  logic [2:0]       mode_q, mode_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;

  logic [N_REQ-1:0] grant_onehot;
  logic [ID_W-1:0]  grant_idx;
  logic             grant_any;
  logic [2:0]       sel_mode;
  logic [31:0]      sel_a;
  logic [31:0]      sel_b;

  fpu_rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req          (req_valid),
    .ptr          (ptr_q),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx),
    .any          (grant_any)
  );

  always_comb begin
    sel_mode = '0;
    sel_a    = '0;
    sel_b    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_onehot[i]) begin
        sel_mode = req_mode[3*i +: 3];
        sel_a    = req_a[32*i +: 32];
        sel_b    = req_b[32*i +: 32];
      end
    end
  end

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // req_ready only rises in IDLE (and never under reset), one-hot on the grant; resp_valid
  // stays high with id/data stable until resp_ready is seen.
  assign req_ready  = (state_q == ST_IDLE && !rst) ? grant_onehot : '0;
  assign busy       = (state_q != ST_IDLE);
  assign fpu_rst_n  = !(rst || state_q == ST_ISSUE);
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;
  assign fpu_mode   = mode_q;
  assign fpu_a      = a_q;
  assign fpu_b      = b_q;
  assign dbg_state  = state_q;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    resp_valid_d = resp_valid_q;
    resp_id_d    = resp_id_q;
    resp_data_d  = resp_data_q;
    mode_d       = mode_q;
    a_d          = a_q;
    b_d          = b_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_any) begin
          mode_d    = sel_mode;
          a_d       = sel_a;
          b_d       = sel_b;
          resp_id_d = grant_idx;
          ptr_d     = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
          // Illegal modes never touch the FPU; answer with qNaN right away.
          if (mode_is_illegal(sel_mode)) begin
            resp_data_d  = QNAN;
            resp_valid_d = 1'b1;
            state_d      = ST_RESP;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        cnt_d   = (mode_q == MODE_DIV) ? CNT_DIV : CNT_ARITH;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == '0) begin
          resp_data_d  = fpu_result;
          resp_valid_d = 1'b1;
          state_d      = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_data_q  <= '0;
      mode_q       <= '0;
      a_q          <= '0;
      b_q          <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
      mode_q       <= mode_d;
      a_q          <= a_d;
      b_q          <= b_d;
    end
  end

`ifdef FPU_ARB_STATS_EN
  logic [31:0] stat_ops_q, stat_ops_d;
  logic [31:0] stat_busy_q, stat_busy_d;

  always_comb begin
    stat_ops_d  = stat_ops_q + 32'(resp_valid_q && resp_ready);
    stat_busy_d = stat_busy_q + 32'(busy);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_ops_q  <= '0;
      stat_busy_q <= '0;
    end else begin
      stat_ops_q  <= stat_ops_d;
      stat_busy_q <= stat_busy_d;
    end
  end

  assign stat_ops  = stat_ops_q;
  assign stat_busy = stat_busy_q;
`endif

endmodule

// File: tb/tb_fpu_32_arbiter.sv
// Bench for fpu_32_arbiter: transaction-level model checked every cycle, plus directed scenarios.
module tb_fpu_32_arbiter;
  import fpu_32_pkg::*;

  localparam int N_REQ     = 4;
  localparam int LAT_ARITH = 2;
  localparam int LAT_DIV   = 40;
  localparam int ID_W      = 2;

  logic                  clk;
  logic                  rst;
  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ-1:0]      req_ready;
  logic [3*N_REQ-1:0]    req_mode;
  logic [32*N_REQ-1:0]   req_a;
  logic [32*N_REQ-1:0]   req_b;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [ID_W-1:0]       resp_id;
  logic [31:0]           resp_data;
  logic                  busy;
  logic [2:0]            fpu_mode;
  logic [31:0]           fpu_a;
  logic [31:0]           fpu_b;
  logic                  fpu_rst_n;
  logic [31:0]           fpu_result;
  arb_state_e            dbg_state;
`ifdef FPU_ARB_STATS_EN
  logic [31:0]           stat_ops;
  logic [31:0]           stat_busy;
`endif

  fpu_32_arbiter #(.N_REQ(N_REQ), .LAT_ARITH(LAT_ARITH), .LAT_DIV(LAT_DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_mode   (req_mode),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .busy       (busy),
    .fpu_mode   (fpu_mode),
    .fpu_a      (fpu_a),
    .fpu_b      (fpu_b),
    .fpu_rst_n  (fpu_rst_n),
    .fpu_result (fpu_result),
    .dbg_state  (dbg_state)
`ifdef FPU_ARB_STATS_EN
    ,
    .stat_ops   (stat_ops),
    .stat_busy  (stat_busy)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- FPU stand-in ----------------
  // Known vectors give real IEEE results; the result only becomes correct once the
  // FPU has been out of reset for its full latency.
  int run_cnt = 0;

  function automatic int lat_of(input logic [2:0] m);
    return (m == 3'b011) ? LAT_DIV : LAT_ARITH;
  endfunction

  function automatic logic [31:0] fpu_func(input logic [2:0] m, input logic [31:0] a, input logic [31:0] b);
    if (m == 3'b001 && a == 32'h41200000 && b == 32'h41A00000) return 32'h41F00000;
    if (m == 3'b011 && a == 32'h42200000 && b == 32'h41000000) return 32'h40A00000;
    if (m == 3'b000 && a == 32'h40400000 && b == 32'h40800000) return 32'h41400000;
    if (m == 3'b010 && a == 32'h41F00000 && b == 32'h41A00000) return 32'h41200000;
    return 32'hBAD00000 ^ a ^ {b[15:0], b[31:16]} ^ {29'd0, m};
  endfunction

  always @(posedge clk) begin
    if (!fpu_rst_n) run_cnt <= 0;
    else if (run_cnt < 100000) run_cnt <= run_cnt + 1;
  end

  assign fpu_result = (run_cnt + 1 >= lat_of(fpu_mode)) ? fpu_func(fpu_mode, fpu_a, fpu_b)
                                                        : (32'hFFFF0000 ^ 32'(run_cnt));

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  int ncyc   = 0;
  int rstn_low = 0;
  int n_hs   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  function automatic int rr_pick(input logic [N_REQ-1:0] v, input int p);
    for (int k = 0; k < N_REQ; k++) begin
      if (v[(p + k) % N_REQ]) return (p + k) % N_REQ;
    end
    return -1;
  endfunction

  // Model state: one op in flight, described by its age since the accept edge.
  bit                  m_valid    = 0;
  bit                  m_inflight = 0;
  bit                  m_fresh    = 0;
  int                  m_acc      = 0;
  int                  m_ptr      = 0;
  logic [2:0]          m_mode     = '0;
  logic [31:0]         m_a        = '0;
  logic [31:0]         m_b        = '0;
  logic [ID_W+31:0]    exp_q[$];

  always @(negedge clk) begin : compare_proc
    int age, rt, g;
    logic ill, exp_rv, exp_rstn;
    logic [N_REQ-1:0] exp_ready;
    ncyc++;
    if (!rst && !fpu_rst_n) rstn_low++;
    age    = ncyc - m_acc;
    ill    = m_mode[2];
    rt     = ill ? 1 : lat_of(m_mode) + 2;
    exp_rv = m_inflight && (age >= rt);
    if (m_valid) begin
      exp_ready = '0;
      if (!rst && !m_inflight) begin
        g = rr_pick(req_valid, m_ptr);
        if (g >= 0) exp_ready[g] = 1'b1;
      end
      exp_rstn = !(rst || (m_inflight && !ill && age == 1));
      check("req_ready", 32'(req_ready), 32'(exp_ready));
      check("busy", 32'(busy), 32'(m_inflight));
      check("resp_valid", 32'(resp_valid), 32'(exp_rv));
      check("fpu_rst_n", 32'(fpu_rst_n), 32'(exp_rstn));
      if (exp_rv && exp_q.size() > 0) begin
        check("resp_id", 32'(resp_id), 32'(exp_q[0][ID_W+31:32]));
        check("resp_data", resp_data, exp_q[0][31:0]);
      end
      if (m_inflight) begin
        check("fpu_mode", 32'(fpu_mode), 32'(m_mode));
        check("fpu_a", fpu_a, m_a);
        check("fpu_b", fpu_b, m_b);
      end
      if (m_fresh) begin
        check("rst_resp_id", 32'(resp_id), 32'd0);
        check("rst_resp_data", resp_data, 32'd0);
        check("rst_fpu_mode", 32'(fpu_mode), 32'd0);
        check("rst_fpu_ab", fpu_a | fpu_b, 32'd0);
      end
    end
    // advance the model across the coming rising edge
    if (rst) begin
      m_valid    = 1;
      m_inflight = 0;
      m_fresh    = 1;
      m_ptr      = 0;
      n_hs       = 0;
      exp_q.delete();
    end else if (m_valid) begin
      if (!m_inflight) begin
        g = rr_pick(req_valid, m_ptr);
        if (g >= 0) begin
          m_inflight = 1;
          m_fresh    = 0;
          m_acc      = ncyc;
          m_mode     = req_mode[3*g +: 3];
          m_a        = req_a[32*g +: 32];
          m_b        = req_b[32*g +: 32];
          m_ptr      = (g + 1) % N_REQ;
          exp_q.push_back({ID_W'(g), m_mode[2] ? 32'h7FC00000 : fpu_func(m_mode, m_a, m_b)});
        end
      end else if (exp_rv && resp_ready) begin
        m_inflight = 0;
        void'(exp_q.pop_front());
        n_hs++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int i, input logic [2:0] m, input logic [31:0] a, input logic [31:0] b);
    req_valid[i]        = 1'b1;
    req_mode[3*i +: 3]  = m;
    req_a[32*i +: 32]   = a;
    req_b[32*i +: 32]   = b;
  endtask

  task automatic wait_ready(input int i, output int acc);
    acc = -1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk); #1;
      if (req_ready[i]) begin
        acc = ncyc;
        break;
      end
    end
    check("ready_seen", 32'(acc >= 0), 32'd1);
  endtask

  task automatic wait_resp(output int cyc);
    cyc = -1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk); #1;
      if (resp_valid) begin
        cyc = ncyc;
        break;
      end
    end
    check("resp_seen", 32'(cyc >= 0), 32'd1);
  endtask

  task automatic run_op(input int i, input logic [2:0] m, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] data, output int id, output int pulses);
    int acc, rc, low0;
    @(posedge clk); #1;
    set_req(i, m, a, b);
    wait_ready(i, acc);
    low0 = rstn_low;
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    wait_resp(rc);
    lat    = rc - acc;
    data   = resp_data;
    id     = int'(resp_id);
    pulses = rstn_low - low0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin : stim
    int lat, id, pulses, acc, rc, g;
    logic [31:0] data;
    rst = 1'b1; req_valid = '0; req_mode = '0; req_a = '0; req_b = '0; resp_ready = 1'b1;

    @(negedge clk); #1;
    check("rst_fpu_rst_n_low", 32'(fpu_rst_n), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    check("post_rst_fpu_rst_n", 32'(fpu_rst_n), 32'd1);

    // 1: add from req0
    run_op(0, 3'b001, 32'h41200000, 32'h41A00000, lat, data, id, pulses);
    check("t1_lat", 32'(lat), 32'd4);
    check("t1_data", data, 32'h41F00000);
    check("t1_id", 32'(id), 32'd0);

    // 2: div from req2
    run_op(2, 3'b011, 32'h42200000, 32'h41000000, lat, data, id, pulses);
    check("t2_lat", 32'(lat), 32'd42);
    check("t2_data", data, 32'h40A00000);
    check("t2_id", 32'(id), 32'd2);
    check("t2_rst_pulse", 32'(pulses), 32'd1);

    // 6: illegal mode from req3 (also brings the pointer back to 0)
    run_op(3, 3'b101, 32'h12345678, 32'h9ABCDEF0, lat, data, id, pulses);
    check("t6_lat", 32'(lat), 32'd1);
    check("t6_data", data, 32'h7FC00000);
    check("t6_id", 32'(id), 32'd3);
    check("t6_no_pulse", 32'(pulses), 32'd0);

    // 3: all four requesters at once
    @(posedge clk); #1;
    for (int i = 0; i < N_REQ; i++) set_req(i, 3'b000, 32'h40400000, 32'h40800000);
    for (int n = 0; n < N_REQ; n++) begin
      g = -1;
      for (int t = 0; t < 200 && g < 0; t++) begin
        @(negedge clk); #1;
        for (int i = 0; i < N_REQ; i++) if (req_ready[i]) g = i;
      end
      check("t3_grant", 32'(g), 32'(n));
      @(posedge clk); #1;
      if (g >= 0) req_valid[g] = 1'b0;
      wait_resp(rc);
      check("t3_id", 32'(resp_id), 32'(n));
      check("t3_data", resp_data, 32'h41400000);
    end

    // 4: response back-pressure while req1 waits
    @(posedge clk); #1;
    resp_ready = 1'b0;
    set_req(0, 3'b001, 32'h41200000, 32'h41A00000);
    set_req(1, 3'b010, 32'h41F00000, 32'h41A00000);
    wait_ready(0, acc);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wait_resp(rc);
    for (int t = 0; t < 5; t++) begin
      check("t4_hold_valid", 32'(resp_valid), 32'd1);
      check("t4_hold_data", resp_data, 32'h41F00000);
      check("t4_hold_id", 32'(resp_id), 32'd0);
      check("t4_no_ready", 32'(req_ready), 32'd0);
      if (t < 4) begin
        @(negedge clk); #1;
      end
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    wait_ready(1, acc);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    wait_resp(rc);
    check("t4_req1_lat", 32'(rc - acc), 32'd4);
    check("t4_req1_data", resp_data, 32'h41200000);
    check("t4_req1_id", 32'(resp_id), 32'd1);

    // 5: reset during a divide
    @(posedge clk); #1;
    set_req(2, 3'b011, 32'h42200000, 32'h41000000);
    wait_ready(2, acc);
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk); #1;
    check("t5_busy_before", 32'(busy), 32'd1);
    check("t5_fpu_rst_n_in_rst", 32'(fpu_rst_n), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_resp_valid", 32'(resp_valid), 32'd0);
    check("t5_resp_data", resp_data, 32'd0);
    check("t5_fpu_a", fpu_a, 32'd0);
    check("t5_state", 32'(dbg_state), 32'(ST_IDLE));
    run_op(1, 3'b010, 32'h41F00000, 32'h41A00000, lat, data, id, pulses);
    check("t5_lat", 32'(lat), 32'd4);
    check("t5_data", data, 32'h41200000);
    check("t5_id", 32'(id), 32'd1);

    repeat (3) @(negedge clk);
    #1;
`ifdef FPU_ARB_STATS_EN
    check("stat_ops", stat_ops, 32'(n_hs));
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion (cycle %0d)", ncyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
